pulse_framer: RTL and testbench

Upstream neighbour of the pulse integrator: sits between the ADC sample stream and the integrator input. Waits for an external chirp trigger, skips a programmable number of samples, then forwards exactly n_samples samples as one AXI-Stream frame with tlast. Samples between pulses are discarded, so every frame the integrator sees is aligned to the chirp. Reports pulse, missed-trigger and overflow status.

---
 rtl/pulse_framer_pkg.sv | 17 +
 rtl/pulse_framer_if.sv | 17 +
 rtl/pulse_framer_trig_sync.sv | 32 +++
 rtl/pulse_framer.sv | 164 ++++++++++++++++
 tb/tb_pulse_framer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_framer_pkg.sv
// Shared types and constants for the pulse framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_framer_pkg;

    // Framer control states; encoding is visible in debug dumps, keep it fixed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DELAY   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam int          DEF_CNT_WIDTH = 16;
    localparam logic [15:0] MISSED_MAX    = 16'hFFFF;

endpackage

// File: rtl/pulse_framer_if.sv
// AXI-Stream style sample bus used on both sides of the framer.
// Latency: n/a (wires only).
// Backpressure: tready from the sink; the slave side never uses tlast.
// Ports/signals: tdata (DW), tvalid, tready, tlast.
interface pulse_framer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    // Source side: drives data/valid/last, observes ready.
    modport master (output tdata, output tvalid, output tlast, input tready);
    // Sink side: ADC input has no framing, so tlast is not part of it.
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pulse_framer_trig_sync.sv
// Brings the asynchronous chirp trigger into aclk and emits a 1-cycle rising-edge pulse.
// Latency: trig_edge is high 3 cycles after trig_in rises.
// Backpressure: none; edges arriving while the framer is busy are handled upstream of here.
// Ports: aclk, aresetn (async active-low), trig_in (async), trig_edge (1-cycle pulse).
module trig_sync (
    input  logic aclk,
    input  logic aresetn,
    input  logic trig_in,
    output logic trig_edge
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_edge;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= trig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // Registered so the pulse is glitch-free and aligned to a full cycle.
            r_edge  <= r_sync2 & ~r_prev;
        end
    end

    assign trig_edge = r_edge;
endmodule

// File: rtl/pulse_framer.sv
// Frames the ADC sample stream per chirp: after a trigger, skip `delay` valid samples, forward `n_samples` with tlast.
// Latency: accepted sample appears on m_axis one cycle later (single output register).
// Backpressure: ADC side never stalls; if the output register is full and not drained, the sample is dropped and overflow sets.
// Ports: aclk/aresetn, s_axis (slave), m_axis (master), trig_in, enable, delay, n_samples,
//        clr_status, pulse_count, missed_trig, overflow.
module pulse_framer
    import pulse_framer_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    pulse_framer_if.slave        s_axis,
    pulse_framer_if.master       m_axis,
    input  logic                 trig_in,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] delay,
    input  logic [CNT_WIDTH-1:0] n_samples,
    input  logic                 clr_status,
    output logic [31:0]          pulse_count,
    output logic [15:0]          missed_trig,
    output logic                 overflow
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                     r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]       r_delay_sh, r_nsamp_sh, r_cnt;
    logic [AXIS_DATA_WIDTH-1:0] r_m_dat;
    logic                       r_m_vld, r_m_last, r_overflow;
    logic [31:0]                r_pulse_cnt;
    logic [15:0]                r_missed;

    logic w_trig_edge;
    logic w_latch, w_cnt_clr, w_cnt_inc, w_accept, w_last, w_pulse_inc, w_missed_inc;
    logic w_can_load;

    trig_sync u_trig_sync (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .trig_in   (trig_in),
        .trig_edge (w_trig_edge)
    );

    // Next-state and per-cycle control. The sample present in the trigger
    // cycle is never counted; counting starts with the next valid sample.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_pulse_inc  = 1'b0;
        w_missed_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_trig_edge) begin
                    w_latch   = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (n_samples == '0)  w_pulse_inc = 1'b1;   // empty pulse: counted, no frame
                    else if (delay == '0) w_state_nxt = CAPTURE;
                    else                  w_state_nxt = DELAY;
                end
            end
            DELAY: begin
                w_missed_inc = w_trig_edge;
                if (s_axis.tvalid) begin
                    if (r_cnt == r_delay_sh - CNT_ONE) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = CAPTURE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                w_missed_inc = w_trig_edge;
                if (s_axis.tvalid) begin
                    w_accept = 1'b1;
                    if (r_cnt == r_nsamp_sh - CNT_ONE) begin
                        w_last      = 1'b1;
                        w_pulse_inc = 1'b1;
                        w_cnt_clr   = 1'b1;
                        // enable only takes effect at a frame boundary
                        w_state_nxt = enable ? ARMED : IDLE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Shadow config and sample counter. Dropped samples still advance the
    // counter so frame timing stays locked to the chirp.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_delay_sh <= '0;
            r_nsamp_sh <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_latch) begin
                r_delay_sh <= delay;
                r_nsamp_sh <= n_samples;
            end
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign w_can_load = ~r_m_vld | m_axis.tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_dat  <= '0;
            r_m_vld  <= 1'b0;
            r_m_last <= 1'b0;
        end else if (w_accept && w_can_load) begin
            r_m_dat  <= s_axis.tdata;
            r_m_last <= w_last;
            r_m_vld  <= 1'b1;
        end else if (m_axis.tready) begin
            r_m_vld  <= 1'b0;
            r_m_last <= 1'b0;
        end
    end

    // Status; a clear in the same cycle as an update wins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pulse_cnt <= '0;
            r_missed    <= '0;
            r_overflow  <= 1'b0;
        end else if (clr_status) begin
            r_pulse_cnt <= '0;
            r_missed    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pulse_inc) r_pulse_cnt <= r_pulse_cnt + 32'd1;
            if (w_missed_inc && (r_missed != MISSED_MAX)) r_missed <= r_missed + 16'd1;
            if (w_accept && !w_can_load) r_overflow <= 1'b1;
        end
    end

    assign s_axis.tready = 1'b1;
    assign m_axis.tdata  = r_m_dat;
    assign m_axis.tvalid = r_m_vld;
    assign m_axis.tlast  = r_m_last;
    assign pulse_count   = r_pulse_cnt;
    assign missed_trig   = r_missed;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_pulse_framer.sv
// Directed bench for pulse_framer: chirp-aligned framing, delay counting, missed triggers,
// overflow on backpressure, empty/one-sample pulses, enable drop and async reset.
// Inputs change 1 ns after each rising edge; output beats are captured at the rising edge.
module tb_pulse_framer;
    import pulse_framer_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          trig_in, enable, clr_status;
    logic [CW-1:0] delay, n_samples;
    logic [31:0]   pulse_count;
    logic [15:0]   missed_trig;
    logic          overflow;

    always #5 aclk = ~aclk;

    pulse_framer_if #(.DW(DW)) s_if ();
    pulse_framer_if #(.DW(DW)) m_if ();

    pulse_framer #(.AXIS_DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .trig_in     (trig_in),
        .enable      (enable),
        .delay       (delay),
        .n_samples   (n_samples),
        .clr_status  (clr_status),
        .pulse_count (pulse_count),
        .missed_trig (missed_trig),
        .overflow    (overflow)
    );

    int passed = 0;
    int total  = 0;

    // Every beat that completes a handshake: {tlast, tdata}.
    logic [32:0] beats[$];
    always @(posedge aclk) begin
        if (aresetn && m_if.tvalid && m_if.tready) beats.push_back({m_if.tlast, m_if.tdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic vld, input logic [31:0] d);
        s_if.tvalid = vld;
        s_if.tdata  = d;
        @(posedge aclk);
        #1;
    endtask

    task automatic clr();
        clr_status = 1'b1;
        cyc(1'b0, 32'h0);
        clr_status = 1'b0;
    endtask

    // Frame of n consecutive values starting at v0, tlast only on the final beat.
    task automatic expect_frame(input string tag, input int q0, input int v0, input int n);
        for (int k = 0; k < n; k++) begin
            check({tag, "_dat"}, beats[q0+k][31:0], v0 + k);
            check({tag, "_last"}, beats[q0+k][32], (k == n - 1));
        end
    endtask

    logic [31:0] exp4 [6];

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        trig_in     = 1'b0;
        enable      = 1'b0;
        clr_status  = 1'b0;
        delay       = 16'd4;
        n_samples   = 16'd8;

        // ---- reset state ----
        repeat (2) @(posedge aclk);
        #1;
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tlast", m_if.tlast, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_pulse", pulse_count, 0);
        check("rst_missed", missed_trig, 0);
        check("rst_ovf", overflow, 0);
        check("s_tready", s_if.tready, 1);
        check("rst_state", dut.r_state, IDLE);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // ---- 1: continuous ramp, edge on sample 10, delay 4, 8 samples ----
        enable = 1'b1;
        beats.delete();
        for (int i = 0; i < 32; i++) begin
            if (i == 7)  trig_in = 1'b1;
            if (i == 12) trig_in = 1'b0;
            cyc(1'b1, i);
        end
        check("t1_nbeats", beats.size(), 8);
        expect_frame("t1", 0, 15, 8);
        check("t1_pulse", pulse_count, 1);
        check("t1_missed", missed_trig, 0);
        check("t1_ovf", overflow, 0);

        // ---- 2: valid toggling, config changed mid-pulse (shadowed) ----
        clr();
        check("clr_pulse", pulse_count, 0);
        beats.delete();
        for (int i = 0; i < 50; i++) begin
            if (i == 17) trig_in = 1'b1;
            if (i == 25) trig_in = 1'b0;
            if (i == 24) begin
                delay     = 16'd1;
                n_samples = 16'd3;
            end
            if (i % 2 == 0) cyc(1'b1, i / 2);
            else            cyc(1'b0, 32'hDEAD_0000 | i);
        end
        delay     = 16'd4;
        n_samples = 16'd8;
        check("t2_nbeats", beats.size(), 8);
        expect_frame("t2", 0, 15, 8);
        check("t2_pulse", pulse_count, 1);

        // ---- 3: trigger during CAPTURE is missed, later one framed ----
        clr();
        beats.delete();
        for (int i = 0; i < 60; i++) begin
            if (i == 7 || i == 14 || i == 30) trig_in = 1'b1;
            if (i == 12 || i == 20 || i == 36) trig_in = 1'b0;
            cyc(1'b1, i);
        end
        check("t3_nbeats", beats.size(), 16);
        expect_frame("t3a", 0, 15, 8);
        expect_frame("t3b", 8, 38, 8);
        check("t3_missed", missed_trig, 1);
        check("t3_pulse", pulse_count, 2);

        // ---- 4: tready low for 3 cycles -> 2 drops, held beat stable ----
        clr();
        beats.delete();
        for (int i = 0; i < 32; i++) begin
            if (i == 7)  trig_in = 1'b1;
            if (i == 12) trig_in = 1'b0;
            m_if.tready = !(i >= 15 && i <= 17);
            cyc(1'b1, i);
            if (i >= 15 && i <= 17) begin
                check("t4_held_dat", m_if.tdata, 15);
                check("t4_held_vld", m_if.tvalid, 1);
            end
        end
        m_if.tready = 1'b1;
        exp4 = '{32'd15, 32'd18, 32'd19, 32'd20, 32'd21, 32'd22};
        check("t4_nbeats", beats.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check("t4_dat", beats[k][31:0], exp4[k]);
            check("t4_last", beats[k][32], (k == 5));
        end
        check("t4_ovf", overflow, 1);
        check("t4_pulse", pulse_count, 1);
        clr();
        check("t4_clr_ovf", overflow, 0);
        check("t4_clr_pulse", pulse_count, 0);

        // ---- 5: n_samples=0 then n_samples=1, delay 0 ----
        delay     = 16'd0;
        n_samples = 16'd0;
        beats.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 7)  trig_in = 1'b1;
            if (i == 12) trig_in = 1'b0;
            cyc(1'b1, i);
        end
        check("t5a_nbeats", beats.size(), 0);
        check("t5a_pulse", pulse_count, 1);
        n_samples = 16'd1;
        for (int i = 0; i < 20; i++) begin
            if (i == 7)  trig_in = 1'b1;
            if (i == 12) trig_in = 1'b0;
            cyc(1'b1, 32'h100 + i);
        end
        check("t5b_nbeats", beats.size(), 1);
        check("t5b_beat", beats[0], {1'b1, 32'h10B});
        check("t5b_pulse", pulse_count, 2);
        check("t5_missed", missed_trig, 0);

        // ---- 6: enable dropped at beat 3, frame completes, then ignored ----
        clr();
        delay     = 16'd4;
        n_samples = 16'd8;
        beats.delete();
        for (int i = 0; i < 40; i++) begin
            if (i == 7 || i == 30) trig_in = 1'b1;
            if (i == 12 || i == 35) trig_in = 1'b0;
            if (i == 17) enable = 1'b0;
            cyc(1'b1, i);
        end
        check("t6_nbeats", beats.size(), 8);
        expect_frame("t6", 0, 15, 8);
        check("t6_state", dut.r_state, IDLE);
        check("t6_pulse", pulse_count, 1);
        check("t6_missed", missed_trig, 0);

        // ---- async reset mid-frame ----
        enable = 1'b1;
        beats.delete();
        for (int i = 0; i < 18; i++) begin
            if (i == 7)  trig_in = 1'b1;
            if (i == 12) trig_in = 1'b0;
            cyc(1'b1, i);
        end
        check("pre_rst_vld", m_if.tvalid, 1);
        check("pre_rst_pulse", pulse_count, 1);
        aresetn = 1'b0;
        #1;
        check("rst2_tvalid", m_if.tvalid, 0);
        check("rst2_tlast", m_if.tlast, 0);
        check("rst2_tdata", m_if.tdata, 0);
        check("rst2_pulse", pulse_count, 0);
        check("rst2_missed", missed_trig, 0);
        check("rst2_ovf", overflow, 0);
        check("rst2_state", dut.r_state, IDLE);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, i);
        check("post_rst_vld", m_if.tvalid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
